// File: rtl/rv_bfms_pkg.sv
// Shared types and constants for the ready/valid bus-functional models.
package rv_bfms_pkg;

    typedef enum logic [1:0] {
        BP_ALWAYS   = 2'd0,
        BP_PERIODIC = 2'd1,
        BP_RANDOM   = 2'd2,
        BP_STALL    = 2'd3
    } bp_mode_e;

    localparam logic [15:0] LFSR_TAP_MASK     = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    // Fibonacci step: taps 16,14,13,11 fold into the new bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] state);
        return {state[14:0], ^(state & LFSR_TAP_MASK)};
    endfunction

endpackage

// File: rtl/rv_bfm_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is always on rdata.
module rv_bfm_fifo
    import rv_bfms_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/rv_data_in_bfm.sv
// Receive-side ready/valid BFM: capture FIFO plus programmable back-pressure.
// Optional protocol checker enabled by defining RV_DATA_IN_PROTO_CHECK_EN.
module rv_data_in_bfm
    import rv_bfms_pkg::*;
#(
    parameter int          DATA_WIDTH = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [DATA_WIDTH-1:0]             data,
    input  logic                              data_valid,
    output logic                              data_ready,
    input  logic [1:0]                        bp_mode,
    input  logic [3:0]                        bp_period,
    output logic [DATA_WIDTH-1:0]             host_data,
    output logic                              host_valid,
    input  logic                              host_ack,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              proto_err
);

    localparam int CW = $clog2(FIFO_DEPTH+1);

    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] count_next;
    logic [15:0]   lfsr;
    logic [3:0]    period_cnt;
    logic [3:0]    last_period;
    logic          gate_next;

    rv_bfm_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (data),
        .rdata (host_data),
        .count (count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign push       = data_valid && data_ready && !fifo_full;
    assign pop        = host_ack && !fifo_empty;
    assign host_valid = !fifo_empty;
    assign count_next = count + CW'(push) - CW'(pop);

    always_comb begin
        gate_next = 1'b0;
        case (bp_mode_e'(bp_mode))
            BP_ALWAYS:   gate_next = 1'b1;
            BP_PERIODIC: gate_next = (period_cnt == bp_period) || (bp_period == 4'd0);
            BP_RANDOM:   gate_next = lfsr[0];
            BP_STALL:    gate_next = 1'b0;
            default:     gate_next = 1'b0;
        endcase
    end

    // Ready looks ahead at next occupancy, so the FIFO can never overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_ready  <= 1'b0;
            lfsr        <= LFSR_SEED;
            period_cnt  <= '0;
            last_period <= '0;
        end else begin
            data_ready  <= gate_next && (count_next < CW'(FIFO_DEPTH));
            lfsr        <= lfsr_step(lfsr);
            last_period <= bp_period;
            if ((bp_period != last_period) || (period_cnt == bp_period)) begin
                period_cnt <= '0;
            end else begin
                period_cnt <= period_cnt + 4'd1;
            end
        end
    end

`ifdef RV_DATA_IN_PROTO_CHECK_EN
    logic                  prev_valid;
    logic                  prev_ready;
    logic [DATA_WIDTH-1:0] prev_data;
    logic                  violation;

    assign violation = prev_valid && !prev_ready && (!data_valid || (data != prev_data));

    // A stalled beat must stay valid and stable until it is taken.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_valid <= 1'b0;
            prev_ready <= 1'b0;
            prev_data  <= '0;
            proto_err  <= 1'b0;
        end else begin
            prev_valid <= data_valid;
            prev_ready <= data_ready;
            prev_data  <= data;
            if (violation) begin
                proto_err <= 1'b1;
`ifdef SIMULATION
                $error("rv_data_in_bfm: protocol violation at %0t", $time);
`endif
            end
        end
    end
`else
    assign proto_err = 1'b0;
`endif

endmodule
